permute_wb_drain: RTL and testbench

//  Receiving end of the permute unit's WBpipe3 writeback packet stream.

---
 rtl/permute_wb_drain_if.sv | 58 +++++
 rtl/permute_wb_drain.sv | 156 +++++++++++++++
 tb/tb_permute_wb_drain.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/permute_wb_drain_if.sv
// ============================================================================
// Module  : permute_wb_drain_if
// Brief   : Bundles the WBpipe3 writeback packet, the register-file write port
//           and the operand-forwarding lookup of the permute writeback drain.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface permute_wb_drain_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned C_CNT_W = $clog2(DEPTH) + 1;

    // Writeback packet: [0:127] data, [128:130] unit tag, [131] wr, [132:138] addr_rt
    logic [0:138]         wb_pkt;
    // Register-file write port
    logic                 rf_wready;
    logic                 rf_we;
    logic [0:6]           rf_waddr;
    logic [0:127]         rf_wdata;
    // Operand-forwarding lookup
    logic [0:6]           fwd_addr;
    logic                 fwd_hit;
    logic [0:127]         fwd_data;
    // Status
    logic [C_CNT_W-1:0]   count;
    logic                 overflow;

    // Producer / RF / issue-stage side
    modport master (
        output wb_pkt,
        output rf_wready,
        output fwd_addr,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  fwd_hit,
        input  fwd_data,
        input  count,
        input  overflow
    );

    // Drain block side
    modport slave (
        input  wb_pkt,
        input  rf_wready,
        input  fwd_addr,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output fwd_hit,
        output fwd_data,
        output count,
        output overflow
    );
endinterface

`default_nettype wire

// File: rtl/permute_wb_drain.sv
// ============================================================================
// Module  : permute_wb_drain
// Brief   : In-order FIFO that captures permute-pipe writeback packets, drains
//           one entry per granted cycle into the RF write port, and answers
//           forwarding lookups for results still in flight.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module permute_wb_drain #(
    parameter int unsigned DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,   // asynchronous, active-low
    permute_wb_drain_if.slave     bus
);
    localparam int unsigned          C_PTR_W = $clog2(DEPTH);
    localparam int unsigned          C_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [C_CNT_W-1:0]   C_FULL  = C_CNT_W'(DEPTH);
    localparam logic [C_PTR_W-1:0]   C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE = C_CNT_W'(1);

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [0:6]           addr_mem_q [DEPTH];
    logic [0:127]         data_mem_q [DEPTH];

    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q,  count_d;
    logic                 overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Packet field extraction
    // ------------------------------------------------------------------
    logic [0:127]         w_in_data;
    logic                 w_in_wr;
    logic [0:6]           w_in_addr;
    logic                 w_unused_tag;

    assign w_in_data    = bus.wb_pkt[0:127];
    assign w_in_wr      = bus.wb_pkt[131];
    assign w_in_addr    = bus.wb_pkt[132:138];
    // The unit tag carries no meaning at this end of the pipe.
    assign w_unused_tag = ^bus.wb_pkt[128:130];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    // Handshake decode: a pop frees the head slot, so a full FIFO can still
    // accept a packet in the same cycle it drains one.
    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == C_FULL);
        w_pop   = !w_empty && bus.rf_wready;
        w_push  = w_in_wr && (!w_full || w_pop);
    end

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        // A valid packet arriving at a full FIFO with no drain is lost.
        if (w_in_wr && w_full && !w_pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_mem_q[wr_ptr_q] <= w_in_addr;
            data_mem_q[wr_ptr_q] <= w_in_data;
        end
    end

    // RF write port presents the head entry, zeroed when empty.
    always_comb begin
        bus.rf_we    = !w_empty;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (!w_empty) begin
            bus.rf_waddr = addr_mem_q[rd_ptr_q];
            bus.rf_wdata = data_mem_q[rd_ptr_q];
        end
    end

    // Forwarding lookup: walk entries oldest to youngest so the youngest
    // match wins, then let a valid incoming packet override everything.
    // The head is included even while it is being popped this cycle.
    always_comb begin
        logic [C_PTR_W-1:0] idx;
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        idx          = rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + C_PTR_W'(i);
            if ((C_CNT_W'(i) < count_q) && (addr_mem_q[idx] == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = data_mem_q[idx];
            end
        end
        if (w_in_wr && (w_in_addr == bus.fwd_addr)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = w_in_data;
        end
        // Lookups are silenced while reset is held.
        if (!reset) begin
            bus.fwd_hit  = 1'b0;
            bus.fwd_data = '0;
        end
    end

    // Status outputs
    always_comb begin
        bus.count    = count_q;
        bus.overflow = overflow_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_permute_wb_drain.sv
// ============================================================================
// Module  : tb_permute_wb_drain
// Brief   : Self-checking bench for permute_wb_drain with a queue-based model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_permute_wb_drain;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    permute_wb_drain_if #(.DEPTH(DEPTH)) bus ();
    permute_wb_drain #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]   addr;
        logic [127:0] data;
    } ent_t;

    ent_t          q[$];
    bit            m_ovf;
    int            checks;
    int            errors;
    logic          exp_hit;
    logic [127:0]  exp_fdata;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [0:138] mk(bit wr, logic [6:0] a, logic [127:0] d);
        logic [2:0] tag;
        tag = 3'($urandom);
        return {d, tag, wr, a};
    endfunction

    // Reference forwarding answer from the current inputs and model queue.
    task automatic model_fwd();
        logic [6:0] pa;
        pa        = bus.wb_pkt[132:138];
        exp_hit   = 1'b0;
        exp_fdata = '0;
        if (reset) begin
            if (bus.wb_pkt[131] && pa == bus.fwd_addr) begin
                exp_hit   = 1'b1;
                exp_fdata = bus.wb_pkt[0:127];
            end else begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].addr == bus.fwd_addr) begin
                        exp_hit   = 1'b1;
                        exp_fdata = q[i].data;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic drive(logic [0:138] p, bit rdy, logic [6:0] fa);
        bus.wb_pkt    = p;
        bus.rf_wready = rdy;
        bus.fwd_addr  = fa;
        #1;
        model_fwd();
    endtask

    // One clock: update the model from the inputs sampled at the edge.
    task automatic tick();
        bit   push, pop, full;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            push = bus.wb_pkt[131];
            pop  = (q.size() != 0) && bus.rf_wready;
            full = (q.size() == DEPTH);
            e.addr = bus.wb_pkt[132:138];
            e.data = bus.wb_pkt[0:127];
            if (pop) void'(q.pop_front());
            if (push) begin
                if (full && !pop) m_ovf = 1'b1;
                else q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        drive(mk(1, 7'd1, rnd128()), 1'b1, 7'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_hold_fwd_hit got %0b want 0", bus.fwd_hit); end
        reset = 1'b1;
        drive('0, 1'b0, 7'd0);
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", bus.rf_we); end
        checks++;
        if (bus.rf_waddr !== 7'd0) begin errors++; $display("FAIL reset_waddr got %0h want 0", bus.rf_waddr); end
        checks++;
        if (bus.rf_wdata !== 128'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", bus.rf_wdata); end
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus.overflow); end
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 128'd0) begin
            errors++; $display("FAIL reset_fwd got %0b/%0h want 0/0", bus.fwd_hit, bus.fwd_data);
        end
        tick();
    endtask

    task automatic test_single();
        logic [127:0] d;
        d = 128'h37363534333231302f2e2d2c2b2a2900;
        drive(mk(1, 7'd5, d), 1'b1, 7'd5);
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL single_no_comb_path got %0b want 0", bus.rf_we); end
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== d) begin
            errors++; $display("FAIL single_fwd_incoming got %0b/%0h want 1/%0h", bus.fwd_hit, bus.fwd_data, d);
        end
        tick();
        drive('0, 1'b1, 7'd5);
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 7'd5 || bus.rf_wdata !== d) begin
            errors++; $display("FAIL single_head got we=%0b a=%0d d=%0h want 1/5/%0h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, d);
        end
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== d) begin
            errors++; $display("FAIL single_fwd_popping_head got %0b/%0h want 1/%0h", bus.fwd_hit, bus.fwd_data, d);
        end
        tick();
        drive('0, 1'b1, 7'd5);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.count !== 3'd0 || bus.rf_waddr !== 7'd0) begin
            errors++; $display("FAIL single_drained got we=%0b cnt=%0d a=%0d want 0/0/0", bus.rf_we, bus.count, bus.rf_waddr);
        end
    endtask

    task automatic test_fill_overflow();
        logic [127:0] dv[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dv[i] = rnd128();
            drive(mk(1, 7'(i), dv[i]), 1'b0, 7'd0);
            tick();
        end
        drive(mk(1, 7'd4, rnd128()), 1'b0, 7'd0);
        checks++;
        if (bus.count !== 3'd4 || bus.rf_waddr !== 7'd0) begin
            errors++; $display("FAIL fill_count got %0d head=%0d want 4/0", bus.count, bus.rf_waddr);
        end
        tick();
        drive('0, 1'b0, 7'd4);
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
            errors++; $display("FAIL fill_overflow got ovf=%0b cnt=%0d want 1/4", bus.overflow, bus.count);
        end
        checks++;
        if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fill_dropped_not_fwd got %0b want 0", bus.fwd_hit); end
        for (int i = 0; i < 4; i++) begin
            drive('0, 1'b1, 7'd0);
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 7'(i) || bus.rf_wdata !== dv[i] || bus.overflow !== 1'b1) begin
                errors++; $display("FAIL fill_drain_%0d got we=%0b a=%0d ovf=%0b want 1/%0d/1", i, bus.rf_we, bus.rf_waddr, bus.overflow, i);
            end
            tick();
        end
        drive('0, 1'b1, 7'd0);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL fill_after_drain got we=%0b ovf=%0b want 0/1", bus.rf_we, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [6:0] order[4];
        order = '{7'd11, 7'd12, 7'd13, 7'd9};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, 7'(10 + i), rnd128()), 1'b0, 7'd0);
            tick();
        end
        drive(mk(1, 7'd9, rnd128()), 1'b1, 7'd0);
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("FAIL fpp_pre_count got %0d want 4", bus.count); end
        tick();
        drive('0, 1'b1, 7'd0);
        checks++;
        if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL fpp_post got cnt=%0d ovf=%0b want 4/0", bus.count, bus.overflow);
        end
        for (int i = 0; i < 4; i++) begin
            drive('0, 1'b1, 7'd0);
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== order[i]) begin
                errors++; $display("FAIL fpp_order_%0d got we=%0b a=%0d want 1/%0d", i, bus.rf_we, bus.rf_waddr, order[i]);
            end
            tick();
        end
    endtask

    task automatic test_forward();
        logic [127:0] a, b, c, x;
        a = rnd128(); b = rnd128(); c = rnd128(); x = rnd128();
        do_reset();
        drive(mk(1, 7'd7, a), 1'b0, 7'd0); tick();
        drive(mk(1, 7'd3, x), 1'b0, 7'd0); tick();
        drive(mk(1, 7'd7, b), 1'b0, 7'd0); tick();
        drive('0, 1'b0, 7'd7);
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== b) begin
            errors++; $display("FAIL fwd_youngest got %0b/%0h want 1/%0h", bus.fwd_hit, bus.fwd_data, b);
        end
        drive(mk(1, 7'd7, c), 1'b0, 7'd7);
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== c) begin
            errors++; $display("FAIL fwd_incoming got %0b/%0h want 1/%0h", bus.fwd_hit, bus.fwd_data, c);
        end
        drive(mk(0, 7'd7, c), 1'b0, 7'd7);
        checks++;
        if (bus.fwd_data !== b) begin
            errors++; $display("FAIL fwd_wr0_ignored got %0h want %0h", bus.fwd_data, b);
        end
        drive('0, 1'b0, 7'd3);
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== x) begin
            errors++; $display("FAIL fwd_middle got %0b/%0h want 1/%0h", bus.fwd_hit, bus.fwd_data, x);
        end
        drive('0, 1'b0, 7'd8);
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 128'd0) begin
            errors++; $display("FAIL fwd_miss got %0b/%0h want 0/0", bus.fwd_hit, bus.fwd_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 7'(i), rnd128()), 1'b0, 7'd0);
            tick();
        end
        drive('0, 1'b0, 7'd1);
        checks++;
        if (bus.count !== 3'd3 || bus.fwd_hit !== 1'b1) begin
            errors++; $display("FAIL areset_pre got cnt=%0d hit=%0b want 3/1", bus.count, bus.fwd_hit);
        end
        #2;
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.count !== 3'd0 || bus.rf_waddr !== 7'd0 || bus.rf_wdata !== 128'd0 || bus.fwd_hit !== 1'b0) begin
            errors++; $display("FAIL areset_immediate got we=%0b cnt=%0d a=%0d hit=%0b want 0/0/0/0", bus.rf_we, bus.count, bus.rf_waddr, bus.fwd_hit);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive('0, 1'b1, 7'd1);
            checks++;
            if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL areset_no_write_%0d got %0b want 0", i, bus.rf_we); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [6:0]   ea;
        logic [127:0] ed;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(mk(($urandom_range(0, 99) < 60), 7'($urandom_range(0, 7)), rnd128()),
                  ($urandom_range(0, 99) < 45), 7'($urandom_range(0, 8)));
            ea = (q.size() != 0) ? q[0].addr : 7'd0;
            ed = (q.size() != 0) ? q[0].data : 128'd0;
            checks++;
            if (bus.rf_we !== (q.size() != 0) || bus.rf_waddr !== ea || bus.rf_wdata !== ed) begin
                errors++; $display("FAIL rand_head cyc %0d got we=%0b a=%0d want %0b/%0d", n, bus.rf_we, bus.rf_waddr, (q.size() != 0), ea);
            end
            checks++;
            if (bus.count !== 3'(q.size()) || bus.overflow !== m_ovf) begin
                errors++; $display("FAIL rand_status cyc %0d got cnt=%0d ovf=%0b want %0d/%0b", n, bus.count, bus.overflow, q.size(), m_ovf);
            end
            checks++;
            if (bus.fwd_hit !== exp_hit || bus.fwd_data !== exp_fdata) begin
                errors++; $display("FAIL rand_fwd cyc %0d got %0b/%0h want %0b/%0h", n, bus.fwd_hit, bus.fwd_data, exp_hit, exp_fdata);
            end
            tick();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_ovf         = 1'b0;
        bus.wb_pkt    = '0;
        bus.rf_wready = 1'b0;
        bus.fwd_addr  = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_forward();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
